// File: rtl/eth_pkg.sv
// eth_pkg: shared definitions for the Ethernet transmit path.
//   ETH_DATA_W / ETH_KEEP_W : AXI-Stream data and byte-enable widths.
//   eth_entry_t             : one 73-bit frame buffer entry {last, keep, data}.
//   WR_ACCEPT / WR_DISCARD  : write-side FSM encodings of eth_tx_frame_buffer.
package eth_pkg;

  localparam int ETH_DATA_W  = 64;
  localparam int ETH_KEEP_W  = 8;
  localparam int ETH_ENTRY_W = 1 + ETH_KEEP_W + ETH_DATA_W;

  typedef struct packed {
    logic                  last;
    logic [ETH_KEEP_W-1:0] keep;
    logic [ETH_DATA_W-1:0] data;
  } eth_entry_t;

  localparam logic [0:0] WR_ACCEPT  = 1'b0;
  localparam logic [0:0] WR_DISCARD = 1'b1;

endpackage

// File: rtl/eth_tx_buffer_ram.sv
// eth_tx_buffer_ram: simple dual-port frame storage (1 write, 1 read port).
// Synchronous read with one cycle of latency; the read register only loads
// when rd_en is high, so it doubles as the first prefetch stage of the reader.
// No reset, so it maps onto block RAM.
//   clock   : single clock
//   wr_en   : write wr_data at wr_addr
//   rd_en   : load rd_data from rd_addr at the next edge
//   rd_data : registered read data, held while rd_en is low
module eth_tx_buffer_ram
  import eth_pkg::*;
#(
  parameter int ADDR_BITS = 9
) (
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  eth_entry_t           wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output eth_entry_t           rd_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  eth_entry_t mem [0:DEPTH-1];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/eth_tx_frame_buffer.sv
// eth_tx_frame_buffer: store-and-forward transmit buffer in front of the MAC.
// A frame becomes visible to the MAC side only once its last beat is stored,
// so the MAC never underruns mid-frame. Frames flagged bad on tlast (tuser=1)
// and frames larger than the buffer are discarded and counted.
//
// Ports:
//   clock, reset     : GT user clock, asynchronous active-high reset
//   s_axis_*         : frame stream from the core (tuser = abort on tlast)
//   m_axis_*         : frame stream to the MAC (tuser tied 0)
//   frames_sent      : wrapping count of frames completed on m_axis
//   frames_dropped   : wrapping count of aborted / oversize frames
//   dbg_wr_state     : current write FSM state (WR_ACCEPT / WR_DISCARD)
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both 1. A source holds tvalid and its payload stable until that happens;
// m_axis follows this rule, and s_axis_tready never depends on s_axis_tvalid.
module eth_tx_frame_buffer
  import eth_pkg::*;
#(
  parameter int ADDR_BITS = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ETH_DATA_W-1:0] s_axis_tdata,
  input  logic [ETH_KEEP_W-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ETH_DATA_W-1:0] m_axis_tdata,
  output logic [ETH_KEEP_W-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [15:0]           frames_sent,
  output logic [15:0]           frames_dropped,
  output logic [0:0]            dbg_wr_state
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int               PTR_W   = ADDR_BITS + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [PTR_W-1:0] PTR_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  logic [PTR_W-1:0] wr_cur;    // speculative write position (open frame)
  logic [PTR_W-1:0] wr_com;    // end of the last committed frame
  logic [PTR_W-1:0] wr_com_q;  // wr_com as seen by the read side
  logic [PTR_W-1:0] rd_ptr;    // next RAM read
  logic [0:0]       wr_state;
  logic             ready_en;  // holds s_axis_tready low for the first cycle after reset

  logic       full;
  logic       oversize;
  logic       in_fire;
  logic       in_abort;
  logic       ram_wr_en;
  eth_entry_t ram_wr_data;

  logic       readable;
  logic       r1_valid;        // RAM read register holds a beat
  logic       out_free;        // output register can take a beat this cycle
  logic       ram_rd_en;
  eth_entry_t ram_rd_data;

  // ---------------------------------------------------------------- write side

  assign full     = (wr_cur - rd_ptr) == DEPTH_P;
  // Full with nothing committed ahead of the open frame: it can never fit.
  assign oversize = (wr_state == WR_ACCEPT) && full && (rd_ptr == wr_com);

  assign s_axis_tready = ready_en && ((wr_state == WR_DISCARD) || !full);
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign in_abort      = s_axis_tlast && s_axis_tuser;

  // The aborting tlast beat is never written; the earlier beats of that frame
  // are abandoned by the rewind and never become readable.
  assign ram_wr_en = in_fire && (wr_state == WR_ACCEPT) && !in_abort;

  always_comb begin
    ram_wr_data      = '0;
    ram_wr_data.last = s_axis_tlast;
    ram_wr_data.keep = s_axis_tkeep;
    ram_wr_data.data = s_axis_tdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state       <= WR_ACCEPT;
      wr_cur         <= '0;
      wr_com         <= '0;
      wr_com_q       <= '0;
      ready_en       <= 1'b0;
      frames_dropped <= '0;
    end else begin
      ready_en <= 1'b1;
      wr_com_q <= wr_com;
      case (wr_state)
        WR_ACCEPT: begin
          if (oversize) begin
            // s_axis_tready is already 0 here because the buffer is full.
            wr_cur         <= wr_com;
            frames_dropped <= frames_dropped + 16'd1;
            wr_state       <= WR_DISCARD;
          end else if (in_fire) begin
            if (in_abort) begin
              wr_cur         <= wr_com;
              frames_dropped <= frames_dropped + 16'd1;
            end else begin
              wr_cur <= wr_cur + PTR_ONE;
              if (s_axis_tlast) begin
                wr_com <= wr_cur + PTR_ONE;
              end
            end
          end
        end
        WR_DISCARD: begin
          // Swallow the rest of the oversize frame; it was already counted.
          if (in_fire && s_axis_tlast) begin
            wr_state <= WR_ACCEPT;
          end
        end
        default: wr_state <= WR_ACCEPT;
      endcase
    end
  end

  assign dbg_wr_state = wr_state;

  // ---------------------------------------------------------------- storage

  eth_tx_buffer_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clock   (clock),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_cur[ADDR_BITS-1:0]),
    .wr_data (ram_wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr[ADDR_BITS-1:0]),
    .rd_data (ram_rd_data)
  );

  // ---------------------------------------------------------------- read side
  // Two prefetch stages: the RAM read register (r1) and the m_axis register.
  // The read side looks at a registered copy of wr_com, so a commit reaches
  // m_axis_tvalid three edges after the committing handshake
  // (commit visible, RAM read, output register).

  assign readable  = rd_ptr != wr_com_q;
  assign out_free  = !m_axis_tvalid || m_axis_tready;
  // r1 is free next cycle if it is empty now or drains into the output now.
  assign ram_rd_en = readable && (!r1_valid || out_free);

  assign m_axis_tuser = 1'b0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr        <= '0;
      r1_valid      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      frames_sent   <= '0;
    end else begin
      if (ram_rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      r1_valid <= ram_rd_en || (r1_valid && !out_free);

      if (out_free) begin
        m_axis_tvalid <= r1_valid;
        if (r1_valid) begin
          m_axis_tdata <= ram_rd_data.data;
          m_axis_tkeep <= ram_rd_data.keep;
          m_axis_tlast <= ram_rd_data.last;
        end
      end

      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        frames_sent <= frames_sent + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_buffer.sv
// tb_eth_tx_frame_buffer: self-checking bench for eth_tx_frame_buffer with a
// 16-entry buffer. Stimulus tasks push expected output beats {last,keep,data}
// into exp_q; a negedge monitor pops and compares every m_axis handshake and
// watches for bubbles inside a frame and for payload changes while stalled.
module tb_eth_tx_frame_buffer;
  import eth_pkg::*;

  localparam int AB = 4;

  logic        clock;
  logic        reset;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] frames_sent;
  logic [15:0] frames_dropped;
  logic [0:0]  dbg_wr_state;

  int checks   = 0;
  int failures = 0;

  logic [72:0] exp_q[$];
  bit          mon_en     = 0;
  bit          in_frame   = 0;
  bit          hold_pend  = 0;
  logic [72:0] held_beat  = '0;
  int          beats_seen = 0;
  bit          sent_done  = 0;

  eth_tx_frame_buffer #(.ADDR_BITS(AB)) dut (
    .clock          (clock),
    .reset          (reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .frames_sent    (frames_sent),
    .frames_dropped (frames_dropped),
    .dbg_wr_state   (dbg_wr_state)
  );

  // ---------------------------------------------------------------- clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clock) begin
    logic [72:0] got;
    logic [72:0] exp;
    if (mon_en && !reset) begin
      got = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (in_frame) begin
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
          failures++;
          $display("FAIL tvalid_bubble: tvalid=%b required 1 inside a frame", m_axis_tvalid);
        end
      end
      if (hold_pend) begin
        checks++;
        if (got !== held_beat || m_axis_tvalid !== 1'b1) begin
          failures++;
          $display("FAIL hold_stable: got %h valid=%b required %h valid=1", got, m_axis_tvalid, held_beat);
        end
      end
      hold_pend = m_axis_tvalid && !m_axis_tready;
      held_beat = got;
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        beats_seen++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got %h with no beat expected", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL beat_data: got %h required %h", got, exp);
          end
        end
        in_frame = !m_axis_tlast;
      end else begin
        in_frame = m_axis_tvalid;
      end
    end else begin
      in_frame  = 0;
      hold_pend = 0;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic idle_inputs();
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    mon_en = 0;
    exp_q.delete();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    mon_en = 1;
  endtask

  // Presents one beat and returns 1 time unit after the edge that took it.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic l, input logic u, output int stalls);
    int waited;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    waited = 0;
    @(negedge clock);
    while (!s_axis_tready && waited < 300) begin
      waited++;
      @(negedge clock);
    end
    if (waited >= 300) begin
      checks++;
      failures++;
      $display("FAIL s_handshake_timeout: tready=%b required 1 within 300 cycles", s_axis_tready);
    end
    @(posedge clock);
    #1;
    stalls = waited;
  endtask

  task automatic send_frame(input int n, input logic [7:0] last_keep,
                            input logic user, output int stalls);
    int          st;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      l = (i == n - 1);
      k = l ? last_keep : 8'hff;
      if (!user) exp_q.push_back({l, k, d});
      send_beat(d, k, l, l && user, st);
      stalls += st;
    end
    idle_inputs();
  endtask

  task automatic wait_drain(output bit ok);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 1000) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    ok = (exp_q.size() == 0);
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    idle_inputs();
    m_axis_tready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000",
               {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser});
    end
    checks++;
    if (m_axis_tdata !== 64'h0 || m_axis_tkeep !== 8'h0) begin
      failures++;
      $display("FAIL reset_payload: got %h/%h required 0/0", m_axis_tdata, m_axis_tkeep);
    end
    checks++;
    if (frames_sent !== 16'd0 || frames_dropped !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters: got %0d/%0d required 0/0", frames_sent, frames_dropped);
    end
    checks++;
    if (dbg_wr_state !== WR_ACCEPT) begin
      failures++;
      $display("FAIL reset_state: got %b required %b", dbg_wr_state, WR_ACCEPT);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: got %b required 0", s_axis_tready);
    end
    @(posedge clock);
    #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_edge: got %b required 1", s_axis_tready);
    end
    mon_en = 1;
  endtask

  task automatic test_single_frame();
    int          st;
    int          seen0;
    bit          ok;
    logic [63:0] d;
    logic [7:0]  k;
    apply_reset();
    m_axis_tready = 1'b1;
    seen0 = beats_seen;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      k = (i == 3) ? 8'h0f : 8'hff;
      exp_q.push_back({(i == 3), k, d});
      send_beat(d, k, (i == 3), 1'b0, st);
      if (i < 3) begin
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
          failures++;
          $display("FAIL early_output: tvalid=%b after beat %0d required 0", m_axis_tvalid, i + 1);
        end
      end
    end
    idle_inputs();
    // Just after the committing edge, then two more edges: still empty.
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (m_axis_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL commit_latency_low: tvalid=%b at %0d edges after commit required 0", m_axis_tvalid, c);
      end
      if (c < 2) begin
        @(posedge clock);
        #1;
      end
    end
    @(posedge clock);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL commit_latency_high: tvalid=%b 3 edges after commit required 1", m_axis_tvalid);
    end
    wait_drain(ok);
    checks++;
    if (!ok || beats_seen - seen0 !== 4) begin
      failures++;
      $display("FAIL single_beats: got %0d beats left=%0d required 4 left=0", beats_seen - seen0, exp_q.size());
    end
    checks++;
    if (frames_sent !== 16'd1) begin
      failures++;
      $display("FAIL single_sent: got %0d required 1", frames_sent);
    end
  endtask

  task automatic test_abort();
    int st;
    bit ok;
    apply_reset();
    m_axis_tready = 1'b1;
    send_frame(3, 8'hff, 1'b1, st);
    send_frame(2, 8'h3f, 1'b0, st);
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL abort_drain: %0d beats left required 0", exp_q.size());
    end
    checks++;
    if (frames_sent !== 16'd1 || frames_dropped !== 16'd1) begin
      failures++;
      $display("FAIL abort_counters: got sent=%0d dropped=%0d required 1/1", frames_sent, frames_dropped);
    end
    // A single-beat aborted frame must leave nothing readable.
    send_frame(1, 8'hff, 1'b1, st);
    repeat (6) @(posedge clock);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || frames_dropped !== 16'd2 || frames_sent !== 16'd1) begin
      failures++;
      $display("FAIL abort_one_beat: got valid=%b dropped=%0d sent=%0d required 0/2/1",
               m_axis_tvalid, frames_dropped, frames_sent);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    bit ok;
    apply_reset();
    m_axis_tready = 1'b0;
    send_frame(3, 8'h01, 1'b0, st);
    send_frame(4, 8'hff, 1'b0, st);
    repeat (5) @(posedge clock);
    #1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      checks++;
      if (m_axis_tvalid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_gap: tvalid=%b on beat slot %0d required 1", m_axis_tvalid, i);
      end
    end
    wait_drain(ok);
    checks++;
    if (!ok || frames_sent !== 16'd2) begin
      failures++;
      $display("FAIL b2b_sent: got %0d left=%0d required 2 left=0", frames_sent, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int st;
    int cyc;
    apply_reset();
    sent_done = 0;
    m_axis_tready = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(8, 8'h7f, 1'b0, st);
        sent_done = 1;
      end
      begin
        cyc = 0;
        while (!(sent_done && exp_q.size() == 0) && cyc < 3000) begin
          @(posedge clock);
          #1;
          m_axis_tready = ($urandom_range(0, 1) == 1);
          cyc++;
        end
      end
    join
    m_axis_tready = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0 || frames_sent !== 16'd3) begin
      failures++;
      $display("FAIL bp_sent: got %0d left=%0d required 3 left=0", frames_sent, exp_q.size());
    end
  endtask

  task automatic test_oversize();
    int          st;
    int          stall_beat;
    int          stall_tot;
    bit          ok;
    logic [63:0] d;
    apply_reset();
    m_axis_tready = 1'b1;
    stall_beat = 0;
    stall_tot  = 0;
    for (int i = 1; i <= 20; i++) begin
      d = {$urandom, $urandom};
      send_beat(d, 8'hff, (i == 20), 1'b0, st);
      if (st != 0 && stall_beat == 0) stall_beat = i;
      stall_tot += st;
      if (i == 17) begin
        checks++;
        if (dbg_wr_state !== WR_DISCARD) begin
          failures++;
          $display("FAIL oversize_state: got %b required %b", dbg_wr_state, WR_DISCARD);
        end
      end
    end
    idle_inputs();
    // 16 beats fill the buffer; the 17th waits exactly one cycle.
    checks++;
    if (stall_beat != 17 || stall_tot != 1) begin
      failures++;
      $display("FAIL oversize_stall: got beat %0d total %0d required beat 17 total 1", stall_beat, stall_tot);
    end
    checks++;
    if (dbg_wr_state !== WR_ACCEPT || frames_dropped !== 16'd1) begin
      failures++;
      $display("FAIL oversize_drop: got state=%b dropped=%0d required 0/1", dbg_wr_state, frames_dropped);
    end
    send_frame(2, 8'h03, 1'b0, st);
    wait_drain(ok);
    checks++;
    if (!ok || frames_sent !== 16'd1 || frames_dropped !== 16'd1) begin
      failures++;
      $display("FAIL oversize_after: got sent=%0d dropped=%0d required 1/1", frames_sent, frames_dropped);
    end
  endtask

  task automatic test_full();
    int          st;
    int          stall_tot;
    bit          ok;
    logic [63:0] d;
    apply_reset();
    m_axis_tready = 1'b0;
    send_frame(10, 8'hff, 1'b0, st);
    // Two beats of the first frame move into the prefetch registers, freeing
    // their RAM slots: 16 - 10 + 2 = 8 beats of the next frame fit.
    stall_tot = 0;
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      exp_q.push_back({1'b0, 8'hff, d});
      send_beat(d, 8'hff, 1'b0, 1'b0, st);
      stall_tot += st;
    end
    checks++;
    if (stall_tot != 0) begin
      failures++;
      $display("FAIL full_fill: got %0d stalls required 0", stall_tot);
    end
    d = {$urandom, $urandom};
    exp_q.push_back({1'b0, 8'hff, d});
    s_axis_tdata  = d;
    s_axis_tkeep  = 8'hff;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if (s_axis_tready !== 1'b0) begin
        failures++;
        $display("FAIL full_ready: got %b required 0 at stall cycle %0d", s_axis_tready, c);
      end
    end
    @(posedge clock);
    #1;
    m_axis_tready = 1'b1;
    send_beat(d, 8'hff, 1'b0, 1'b0, st);
    d = {$urandom, $urandom};
    exp_q.push_back({1'b1, 8'h0f, d});
    send_beat(d, 8'h0f, 1'b1, 1'b0, st);
    idle_inputs();
    wait_drain(ok);
    checks++;
    if (!ok || frames_sent !== 16'd2) begin
      failures++;
      $display("FAIL full_resume: got sent=%0d left=%0d required 2 left=0", frames_sent, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int          st;
    bit          ok;
    logic [63:0] d;
    apply_reset();
    m_axis_tready = 1'b0;
    send_frame(6, 8'hff, 1'b0, st);
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      send_beat(d, 8'hff, 1'b0, 1'b0, st);
    end
    // Input frame still open with a beat on the bus; output frame under way.
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    mon_en = 0;
    exp_q.delete();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 4'b0000 ||
        m_axis_tdata !== 64'h0 || m_axis_tkeep !== 8'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got rdy=%b vld=%b last=%b user=%b data=%h keep=%h required all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, m_axis_tkeep);
    end
    checks++;
    if (frames_sent !== 16'd0 || frames_dropped !== 16'd0) begin
      failures++;
      $display("FAIL midreset_counters: got %0d/%0d required 0/0", frames_sent, frames_dropped);
    end
    apply_reset();
    m_axis_tready = 1'b1;
    send_frame(2, 8'h1f, 1'b0, st);
    wait_drain(ok);
    checks++;
    if (!ok || frames_sent !== 16'd1) begin
      failures++;
      $display("FAIL midreset_after: got sent=%0d left=%0d required 1 left=0", frames_sent, exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    idle_inputs();
    m_axis_tready = 1'b0;
    reset = 1'b1;
    test_reset();
    test_single_frame();
    test_abort();
    test_back_to_back();
    test_backpressure();
    test_oversize();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
